// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for the shared iterative divider.
// Issues, stalls EX, holds HI/LO and aborts on flush.
module div_issue_ctrl #(
  parameter int TIMEOUT   = 64,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_div_req,
  input  logic        ex_div_signed,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  input  logic        ex_advance,
  input  logic        ex_flush,
  output logic        stall_req,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        err_timeout,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DR_LOAD =
    CNT_W'(DRAIN_CYC - 1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] dcnt, nxt_dcnt;
  logic             nxt_start, nxt_annul;
  logic             nxt_signed, nxt_valid;
  logic             nxt_err;
  logic [31:0]      nxt_op1, nxt_op2;
  logic [31:0]      nxt_hi, nxt_lo;
  logic             issue_ok;

  // never issue while annul is still draining
  assign issue_ok = ex_div_req && !ex_flush
                    && !div_annul;

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_dcnt   = dcnt;
    nxt_start  = div_start;
    nxt_annul  = div_annul;
    nxt_signed = div_signed;
    nxt_op1    = div_op1;
    nxt_op2    = div_op2;
    nxt_hi     = res_hi;
    nxt_lo     = res_lo;
    nxt_valid  = res_valid;
    nxt_err    = err_timeout;
    stall_req  = 1'b0;

    if (div_annul) begin
      if (dcnt == '0) nxt_annul = 1'b0;
      else nxt_dcnt = dcnt - CNT_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (issue_ok) begin
          stall_req  = 1'b1;
          nxt_op1    = ex_op1;
          nxt_op2    = ex_op2;
          nxt_signed = ex_div_signed;
          nxt_start  = 1'b1;
          nxt_cnt    = '0;
          nxt_state  = RUN;
        end
      end
      RUN: begin
        stall_req = 1'b1;
        nxt_cnt   = cnt + CNT_W'(1);
        if (ex_flush) begin
          nxt_start = 1'b0;
          nxt_annul = 1'b1;
          nxt_dcnt  = DR_LOAD;
          nxt_state = DRAIN;
        end else if (!div_busy) begin
          nxt_hi    = div_hi;
          nxt_lo    = div_lo;
          nxt_start = 1'b0;
          nxt_valid = 1'b1;
          nxt_state = DONE;
        end else if (cnt == TO_LAST) begin
          nxt_err   = 1'b1;
          nxt_hi    = '0;
          nxt_lo    = '0;
          nxt_start = 1'b0;
          nxt_annul = 1'b1;
          nxt_dcnt  = DR_LOAD;
          nxt_valid = 1'b1;
          nxt_state = DONE;
        end
      end
      DONE: begin
        if (ex_advance || ex_flush) begin
          nxt_valid = 1'b0;
          nxt_state = IDLE;
        end
      end
      DRAIN: begin
        if (!div_annul || dcnt == '0)
          nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      dcnt        <= '0;
      div_start   <= 1'b0;
      div_annul   <= 1'b0;
      div_signed  <= 1'b0;
      div_op1     <= '0;
      div_op2     <= '0;
      res_hi      <= '0;
      res_lo      <= '0;
      res_valid   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      dcnt        <= nxt_dcnt;
      div_start   <= nxt_start;
      div_annul   <= nxt_annul;
      div_signed  <= nxt_signed;
      div_op1     <= nxt_op1;
      div_op2     <= nxt_op2;
      res_hi      <= nxt_hi;
      res_lo      <= nxt_lo;
      res_valid   <= nxt_valid;
      err_timeout <= nxt_err;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural
// iterative-divider model and a result scoreboard.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_div_req = 1'b0;
  logic        ex_div_signed = 1'b0;
  logic [31:0] ex_op1 = '0;
  logic [31:0] ex_op2 = '0;
  logic        ex_advance = 1'b0;
  logic        ex_flush = 1'b0;
  logic        stall_req, res_valid;
  logic [31:0] res_hi, res_lo;
  logic        err_timeout;
  logic        div_start, div_annul, div_signed;
  logic [31:0] div_op1, div_op2;
  logic [31:0] div_hi, div_lo;
  logic        div_busy;
  logic        hang = 1'b0;
  int          dcyc;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] sb[$];

  div_issue_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ex_div_req(ex_div_req),
    .ex_div_signed(ex_div_signed),
    .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_advance(ex_advance), .ex_flush(ex_flush),
    .stall_req(stall_req), .res_valid(res_valid),
    .res_hi(res_hi), .res_lo(res_lo),
    .err_timeout(err_timeout),
    .div_start(div_start), .div_annul(div_annul),
    .div_signed(div_signed),
    .div_op1(div_op1), .div_op2(div_op2),
    .div_hi(div_hi), .div_lo(div_lo),
    .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(
    input logic s, input logic [31:0] a,
    input logic [31:0] b);
    logic signed [31:0] sa, sd;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    sa = a;
    sd = b;
    if (s) begin
      q = sa / sd;
      r = sa % sd;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // divider model: ready after 34 cycles of start
  // (2 for divide-by-zero), never when hang is set
  always @(posedge clk or negedge resetn)
    if (!resetn) dcyc <= 0;
    else if (!div_start) dcyc <= 0;
    else dcyc <= dcyc + 1;

  assign div_busy = div_start && (hang ||
    dcyc < ((div_op2 == 32'd0) ? 2 : 34));
  assign {div_hi, div_lo} =
    ref_div(div_signed, div_op1, div_op2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s,
    input logic [31:0] a, input logic [31:0] b);
    ex_div_signed = s;
    ex_op1 = a;
    ex_op2 = b;
    ex_div_req = 1'b1;
  endtask

  task automatic wait_valid(input int lim,
    output int cyc);
    cyc = 0;
    while (!res_valid && cyc < lim) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_ex();
    ex_div_req = 1'b0;
    ex_advance = 1'b1;
    tick();
    ex_advance = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) tick();
    n_chk++;
    if ({stall_req, res_valid, err_timeout,
         div_start, div_annul, div_signed}
        !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b exp 0",
        {stall_req, res_valid, err_timeout,
         div_start, div_annul, div_signed});
    end
    n_chk++;
    if ({res_hi, res_lo, div_op1, div_op2}
        !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h exp 0",
        {res_hi, res_lo, div_op1, div_op2});
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_signed_div();
    int cyc, bad;
    logic [63:0] exp;
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(1'b1, 32'hFFFFFFF9, 32'd2);
    #1;
    n_chk++;
    if (stall_req !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_issue_stall: got %b exp 1",
        stall_req);
    end
    cyc = 0;
    bad = 0;
    while (!res_valid && cyc < 100) begin
      if (stall_req !== 1'b1) bad++;
      tick();
      cyc++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL t1_run_stall: got %0d low exp 0",
        bad);
    end
    n_chk++;
    if (res_valid !== 1'b1 || cyc < 34 || cyc > 38)
    begin
      n_fail++;
      $display("FAIL t1_latency: got %0d v=%b exp 36",
        cyc, res_valid);
    end
    exp = sb.pop_front();
    n_chk++;
    if ({res_hi, res_lo} !== exp) begin
      n_fail++;
      $display("FAIL t1_result: got %h exp %h",
        {res_hi, res_lo}, exp);
    end
    n_chk++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_done_stall: got %b exp 0",
        stall_req);
    end
    release_ex();
  endtask

  task automatic test_hold();
    int cyc, bad;
    logic [63:0] exp;
    sb.push_back({32'd2, 32'd14});
    issue(1'b0, 32'd100, 32'd7);
    wait_valid(100, cyc);
    exp = sb.pop_front();
    n_chk++;
    if (res_valid !== 1'b1 ||
        {res_hi, res_lo} !== exp) begin
      n_fail++;
      $display("FAIL t2_result: got %b/%h exp 1/%h",
        res_valid, {res_hi, res_lo}, exp);
    end
    bad = 0;
    repeat (5) begin
      tick();
      if (res_valid !== 1'b1 || div_start !== 1'b0
          || stall_req !== 1'b0
          || {res_hi, res_lo} !== exp) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL t2_hold: got %0d bad exp 0", bad);
    end
    release_ex();
    n_chk++;
    if ({res_valid, div_start, stall_req} !== 3'b0)
    begin
      n_fail++;
      $display("FAIL t2_idle: got %b exp 000",
        {res_valid, div_start, stall_req});
    end
    tick();
    n_chk++;
    if (div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_no_reissue: got %b exp 0",
        div_start);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    logic [63:0] exp;
    sb.push_back(64'd0);
    issue(1'b0, 32'd5, 32'd0);
    wait_valid(20, cyc);
    exp = sb.pop_front();
    n_chk++;
    if (res_valid !== 1'b1 || cyc > 4) begin
      n_fail++;
      $display("FAIL t3_latency: got %0d v=%b exp <=4",
        cyc, res_valid);
    end
    n_chk++;
    if ({res_hi, res_lo} !== exp ||
        err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_result: got %h/%b exp %h/0",
        {res_hi, res_lo}, err_timeout, exp);
    end
    release_ex();
  endtask

  task automatic test_flush();
    int cyc, ann, bad;
    logic [63:0] exp;
    issue(1'b0, 32'hFFFFFFFF, 32'd3);
    repeat (10) tick();
    ex_flush = 1'b1;
    ex_div_req = 1'b0;
    tick();
    ex_flush = 1'b0;
    ann = 0;
    bad = 0;
    repeat (8) begin
      if (div_annul) ann++;
      if (res_valid || div_start || stall_req) bad++;
      tick();
    end
    n_chk++;
    if (ann != 3) begin
      n_fail++;
      $display("FAIL t4_annul: got %0d exp 3", ann);
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL t4_quiet: got %0d bad exp 0", bad);
    end
    sb.push_back({32'd0, 32'd3});
    issue(1'b0, 32'd9, 32'd3);
    wait_valid(100, cyc);
    exp = sb.pop_front();
    n_chk++;
    if (res_valid !== 1'b1 ||
        {res_hi, res_lo} !== exp) begin
      n_fail++;
      $display("FAIL t4_after: got %b/%h exp 1/%h",
        res_valid, {res_hi, res_lo}, exp);
    end
    release_ex();
  endtask

  task automatic test_async_reset();
    int cyc;
    logic [63:0] exp;
    issue(1'b1, 32'h12345678, 32'd3);
    repeat (20) tick();
    #2;
    ex_div_req = 1'b0;
    resetn = 1'b0;
    #1;
    n_chk++;
    if ({stall_req, res_valid, err_timeout,
         div_start, div_annul, div_signed,
         res_hi, res_lo, div_op1, div_op2}
        !== 134'd0) begin
      n_fail++;
      $display("FAIL t5_async: got %b%b%b%b%b%b exp 0",
        stall_req, res_valid, err_timeout,
        div_start, div_annul, div_signed);
    end
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    sb.push_back({32'd1, 32'hFFFFFFFD});
    issue(1'b1, 32'd7, 32'hFFFFFFFE);
    wait_valid(100, cyc);
    exp = sb.pop_front();
    n_chk++;
    if (res_valid !== 1'b1 ||
        {res_hi, res_lo} !== exp) begin
      n_fail++;
      $display("FAIL t5_after: got %b/%h exp 1/%h",
        res_valid, {res_hi, res_lo}, exp);
    end
    release_ex();
  endtask

  task automatic test_timeout();
    int cyc, ann;
    hang = 1'b1;
    issue(1'b0, 32'd1000, 32'd10);
    cyc = 0;
    while (!err_timeout && cyc < 100) begin
      tick();
      cyc++;
    end
    n_chk++;
    if (err_timeout !== 1'b1 || cyc != 65) begin
      n_fail++;
      $display("FAIL t6_fire: got %0d e=%b exp 65",
        cyc, err_timeout);
    end
    n_chk++;
    if (res_valid !== 1'b1 || stall_req !== 1'b0 ||
        {res_hi, res_lo} !== 64'd0) begin
      n_fail++;
      $display("FAIL t6_done: got %b%b/%h exp 10/0",
        res_valid, stall_req, {res_hi, res_lo});
    end
    ann = 0;
    repeat (6) begin
      if (div_annul) ann++;
      tick();
    end
    n_chk++;
    if (ann != 3 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_annul: got %0d v=%b exp 3",
        ann, res_valid);
    end
    hang = 1'b0;
    release_ex();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic s;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 6; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom | 32'd1;
      if (i == 0) b = 32'd1;
      if (s && b == 32'hFFFFFFFF) b = 32'd3;
      sb.push_back(ref_div(s, a, b));
      if (i > 0) begin
        ex_advance = 1'b1;
        issue(s, a, b);
        tick();
        ex_advance = 1'b0;
        #1;
        n_chk++;
        if (div_start !== 1'b0 || stall_req !== 1'b1
            || res_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_bubble: got %b%b%b exp 010",
            div_start, stall_req, res_valid);
        end
      end else begin
        issue(s, a, b);
      end
      wait_valid(100, cyc);
      exp = sb.pop_front();
      n_chk++;
      if (res_valid !== 1'b1 ||
          {res_hi, res_lo} !== exp) begin
        n_fail++;
        $display("FAIL b2b_result%0d: got %b/%h exp 1/%h",
          i, res_valid, {res_hi, res_lo}, exp);
      end
    end
    release_ex();
    n_chk++;
    if (err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_sticky: got %b exp 1",
        err_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_signed_div();
    test_hold();
    test_div_zero();
    test_flush();
    test_async_reset();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang exp finish");
    $fatal(1, "bench time limit");
  end

endmodule
